ptw_arbiter: RTL

PTW_ARBITER -- requirements
Module: ptw_arbiter

---
 rtl/ptw_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ptw_arbiter.sv
// Arbitrates ITLB and DTLB miss requests onto one shared page-table walker.
// One walk is outstanding at a time; same-page misses share a single walk.

module ptw_arbiter_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic gnt,
  input  logic in_resp,
  input  logic resp_ready,
  output logic resp_valid,
  output logic pend_left
);
  logic pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        pend <= 1'b0;
    else if (load)                     pend <= gnt;
    else if (resp_valid && resp_ready) pend <= 1'b0;
  end

  assign resp_valid = in_resp && pend;
  // Still owed a response after this cycle's handshake (if any).
  assign pend_left  = pend && !(resp_valid && resp_ready);
endmodule

module ptw_arbiter #(
  parameter int VADDR_W = 32,
  parameter int PTE_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               itlb_req_valid_i,
  output logic               itlb_req_ready_o,
  input  logic [VADDR_W-1:0] itlb_vaddr_i,
  output logic               itlb_resp_valid_o,
  input  logic               itlb_resp_ready_i,
  output logic [PTE_W-1:0]   itlb_pte_o,
  input  logic               dtlb_req_valid_i,
  output logic               dtlb_req_ready_o,
  input  logic [VADDR_W-1:0] dtlb_vaddr_i,
  output logic               dtlb_resp_valid_o,
  input  logic               dtlb_resp_ready_i,
  output logic [PTE_W-1:0]   dtlb_pte_o,
  output logic               ptw_req_valid_o,
  input  logic               ptw_req_ready_i,
  output logic [VADDR_W-1:0] ptw_vaddr_o,
  input  logic               ptw_resp_valid_i,
  output logic               ptw_resp_ready_o,
  input  logic [PTE_W-1:0]   ptw_pte_i,
  output logic               busy_o
);
  localparam int NUM_LANES = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                              state, state_nxt;
  logic                                last_gnt;  // 1: DTLB was granted last
  logic [VADDR_W-1:0]                  vaddr_q;
  logic [PTE_W-1:0]                    pte_q;
  logic [NUM_LANES-1:0]                req_valid, gnt, resp_ready, resp_valid, pend_left;
  logic [NUM_LANES-1:0][VADDR_W-1:0]   req_vaddr;
  logic                                same_page, accept;

  assign req_valid  = {dtlb_req_valid_i, itlb_req_valid_i};
  assign req_vaddr  = {dtlb_vaddr_i, itlb_vaddr_i};
  assign resp_ready = {dtlb_resp_ready_i, itlb_resp_ready_i};
  assign same_page  = req_vaddr[0][VADDR_W-1:12] == req_vaddr[1][VADDR_W-1:12];

  // Ready is the grant itself, so acceptance happens in the grant cycle.
  always_comb begin
    gnt = '0;
    if (state == IDLE) begin
      if (&req_valid) gnt = same_page ? 2'b11 : (last_gnt ? 2'b01 : 2'b10);
      else            gnt = req_valid;
    end
  end
  assign accept = |gnt;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    ptw_arbiter_lane u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (accept),
      .gnt        (gnt[l]),
      .in_resp    (state == RESP),
      .resp_ready (resp_ready[l]),
      .resp_valid (resp_valid[l]),
      .pend_left  (pend_left[l])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)           state_nxt = ISSUE;
      ISSUE:   if (ptw_req_ready_i)  state_nxt = WAIT;
      WAIT:    if (ptw_resp_valid_i) state_nxt = RESP;
      RESP:    if (~|pend_left)      state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
      vaddr_q  <= '0;
      pte_q    <= '0;
    end else begin
      if (accept) begin
        last_gnt <= gnt[1];
        vaddr_q  <= gnt[0] ? req_vaddr[0] : req_vaddr[1];
      end
      if (state == WAIT && ptw_resp_valid_i) pte_q <= ptw_pte_i;
    end
  end

  // Handshake outputs are held low while reset is asserted, even with valid inputs.
  always_comb begin
    itlb_req_ready_o  = rst_n && gnt[0];
    dtlb_req_ready_o  = rst_n && gnt[1];
    ptw_req_valid_o   = rst_n && (state == ISSUE);
    ptw_resp_ready_o  = rst_n && (state == WAIT);
    itlb_resp_valid_o = resp_valid[0];
    dtlb_resp_valid_o = resp_valid[1];
    busy_o            = state != IDLE;
    ptw_vaddr_o       = vaddr_q;
    itlb_pte_o        = pte_q;
    dtlb_pte_o        = pte_q;
  end
endmodule
